// File: rtl/ofdm_subcarrier_mapper.sv
// 802.11a subcarrier mapper: packs interleaved bits into BPSK/QPSK/16-QAM points,
// inserts the four scrambled pilots and streams 52 subcarriers per OFDM symbol.
`timescale 1ns/1ps
module ofdm_subcarrier_mapper #(
  parameter int OUT_W     = 8,
  parameter int SYM_CNT_W = 8
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic                        In_Bit,
  input  logic                        In_Valid,
  output logic                        In_Ready,
  input  logic [1:0]                  Mode,
  output logic signed [OUT_W-1:0]     Out_I,
  output logic signed [OUT_W-1:0]     Out_Q,
  output logic                        Out_Valid,
  output logic [5:0]                  Out_Index,
  output logic                        Sym_Start,
  output logic                        Sym_End,
  output logic [SYM_CNT_W-1:0]        Sym_Count
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PILOT = 2'd2} state_t;
  typedef enum logic [1:0] {M_BPSK = 2'd0, M_QPSK = 2'd1, M_QAM16 = 2'd2} mode_t;

  state_t state_q, state_d;
  mode_t  mode_q, mode_in, cur_mode;

  logic [5:0] slot, slot_nxt;
  logic [1:0] bit_cnt, last_idx;
  logic [3:0] acc, bits;
  logic [6:0] lfsr;
  logic       accept, first_bit, last_bit, pilot_next, pilot_neg;
  logic signed [7:0] data_i, data_q, pilot_i;

  function automatic logic signed [7:0] qam_level(input logic hi, input logic lo);
    case ({hi, lo})
      2'b00:   qam_level = -8'sd61;
      2'b01:   qam_level = -8'sd20;
      2'b11:   qam_level = 8'sd20;
      default: qam_level = 8'sd61;
    endcase
  endfunction

  assign In_Ready = (state_q == DATA);

  always_comb begin
    accept    = In_Valid && (state_q == DATA) && !Start;
    first_bit = (slot == 6'd0) && (bit_cnt == 2'd0);

    case (Mode)
      2'b01:   mode_in = M_QPSK;
      2'b10:   mode_in = M_QAM16;
      default: mode_in = M_BPSK;
    endcase
    // The first bit of a symbol maps with the Mode it arrives with, later bits with mode_q.
    cur_mode = first_bit ? mode_in : mode_q;

    case (cur_mode)
      M_QPSK:  last_idx = 2'd1;
      M_QAM16: last_idx = 2'd3;
      default: last_idx = 2'd0;
    endcase
    last_bit = (bit_cnt == last_idx);

    bits          = acc;
    bits[bit_cnt] = In_Bit;

    case (cur_mode)
      M_QPSK: begin
        data_i = bits[0] ? 8'sd45 : -8'sd45;
        data_q = bits[1] ? 8'sd45 : -8'sd45;
      end
      M_QAM16: begin
        data_i = qam_level(bits[0], bits[1]);
        data_q = qam_level(bits[2], bits[3]);
      end
      default: begin
        data_i = bits[0] ? 8'sd64 : -8'sd64;
        data_q = '0;
      end
    endcase

    slot_nxt   = (slot == 6'd51) ? '0 : slot + 6'd1;
    pilot_next = (slot_nxt == 6'd5) || (slot_nxt == 6'd19) ||
                 (slot_nxt == 6'd32) || (slot_nxt == 6'd46);

    pilot_neg = lfsr[6] ^ lfsr[3];
    pilot_i   = (pilot_neg ^ (slot == 6'd46)) ? -8'sd64 : 8'sd64;
  end

  always_comb begin
    state_d = state_q;
    if (Start) begin
      state_d = DATA;
    end else begin
      case (state_q)
        DATA:    if (accept && last_bit && pilot_next) state_d = PILOT;
        PILOT:   state_d = DATA;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      slot      <= '0;
      bit_cnt   <= '0;
      acc       <= '0;
      lfsr      <= '1;
      mode_q    <= M_BPSK;
      Out_I     <= '0;
      Out_Q     <= '0;
      Out_Valid <= 1'b0;
      Out_Index <= '0;
      Sym_Start <= 1'b0;
      Sym_End   <= 1'b0;
      Sym_Count <= '0;
    end else begin
      Out_Valid <= 1'b0;
      Sym_Start <= 1'b0;
      Sym_End   <= 1'b0;
      if (Start) begin
        slot      <= '0;
        bit_cnt   <= '0;
        acc       <= '0;
        lfsr      <= '1;
        Sym_Count <= '0;
      end else if (accept) begin
        if (first_bit) mode_q <= mode_in;
        if (last_bit) begin
          bit_cnt   <= '0;
          acc       <= '0;
          Out_I     <= OUT_W'(data_i);
          Out_Q     <= OUT_W'(data_q);
          Out_Valid <= 1'b1;
          Out_Index <= slot;
          Sym_Start <= (slot == 6'd0);
          Sym_End   <= (slot == 6'd51);
          slot      <= slot_nxt;
          if (slot == 6'd51) begin
            lfsr      <= {lfsr[5:0], lfsr[6] ^ lfsr[3]};
            Sym_Count <= Sym_Count + SYM_CNT_W'(1);
          end
        end else begin
          acc[bit_cnt] <= In_Bit;
          bit_cnt      <= bit_cnt + 2'd1;
        end
      end else if (state_q == PILOT) begin
        Out_I     <= OUT_W'(pilot_i);
        Out_Q     <= '0;
        Out_Valid <= 1'b1;
        Out_Index <= slot;
        slot      <= slot_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ofdm_subcarrier_mapper.sv
// Directed bench for ofdm_subcarrier_mapper: per-scenario tasks with inline checks.
`timescale 1ns/1ps
module tb_ofdm_subcarrier_mapper;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic              Start = 1'b0;
  logic              In_Bit = 1'b0;
  logic              In_Valid = 1'b0;
  logic [1:0]        Mode = 2'b00;
  logic              In_Ready;
  logic signed [7:0] Out_I, Out_Q;
  logic              Out_Valid;
  logic [5:0]        Out_Index;
  logic              Sym_Start, Sym_End;
  logic [7:0]        Sym_Count;

  typedef struct {
    logic [5:0]        idx;
    logic signed [7:0] i;
    logic signed [7:0] q;
    logic              ss;
    logic              se;
    logic [7:0]        cnt;
  } beat_t;

  beat_t beats[$];
  int n_cmp = 0;
  int n_bad = 0;
  int stall_cnt = 0;

  ofdm_subcarrier_mapper #(.OUT_W(8), .SYM_CNT_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .In_Bit(In_Bit), .In_Valid(In_Valid),
    .In_Ready(In_Ready), .Mode(Mode), .Out_I(Out_I), .Out_Q(Out_Q), .Out_Valid(Out_Valid),
    .Out_Index(Out_Index), .Sym_Start(Sym_Start), .Sym_End(Sym_End), .Sym_Count(Sym_Count)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    #1;
    if (Out_Valid === 1'b1)
      beats.push_back('{Out_Index, Out_I, Out_Q, Sym_Start, Sym_End, Sym_Count});
  end

  function automatic bit is_pilot(input int s);
    return (s == 5) || (s == 19) || (s == 32) || (s == 46);
  endfunction

  task automatic pulse_start();
    @(negedge Clock); Start = 1'b1;
    @(negedge Clock); Start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_bit(input logic b);
    int g = 0;
    In_Bit = b;
    In_Valid = 1'b1;
    while (In_Ready !== 1'b1 && g < 8) begin
      @(negedge Clock);
      g++;
    end
    stall_cnt += g;
    if (g >= 8) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout In_Ready=%b required 1", In_Ready);
    end
    @(negedge Clock);
  endtask

  task automatic stop_bits();
    In_Valid = 1'b0;
    repeat (3) @(negedge Clock);
  endtask

  task automatic test_reset();
    logic [7:0] flat;
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    pulse_start();
    for (int j = 0; j < 10; j++) send_bit(j[0]);
    In_Valid = 1'b0;
    #2 Reset = 1'b0;
    #1;
    flat = {Out_Valid, Sym_Start, Sym_End, In_Ready, |Out_I, |Out_Q, |Out_Index, |Sym_Count};
    n_cmp++; if (flat !== 8'h00) begin n_bad++; $display("FAIL reset_outputs flags=%b required 00000000", flat); end
    n_cmp++; if (Out_Index !== 6'd0) begin n_bad++; $display("FAIL reset_index got %0d required 0", Out_Index); end
    @(negedge Clock);
    n_cmp++; if (In_Ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b required 0", In_Ready); end
    Reset = 1'b1;
    @(negedge Clock);
    beats.delete();
    pulse_start();
    for (int j = 0; j < 48; j++) send_bit(1'b0);
    stop_bits();
    n_cmp++; if (beats.size() != 52) begin n_bad++; $display("FAIL reset_beats got %0d required 52", beats.size()); end
    if (beats.size() > 5) begin
      n_cmp++; if (beats[0].idx !== 6'd0) begin n_bad++; $display("FAIL reset_first_idx got %0d required 0", beats[0].idx); end
      n_cmp++; if (beats[0].ss !== 1'b1) begin n_bad++; $display("FAIL reset_first_ss got %b required 1", beats[0].ss); end
      n_cmp++; if (beats[0].cnt !== 8'd0) begin n_bad++; $display("FAIL reset_first_cnt got %0d required 0", beats[0].cnt); end
      n_cmp++; if (int'(beats[5].i) !== 64) begin n_bad++; $display("FAIL reset_pilot5 got %0d required 64", beats[5].i); end
    end
  endtask

  task automatic test_bpsk();
    int k = 0;
    int exp_i;
    Mode = 2'b00;
    beats.delete();
    pulse_start();
    stall_cnt = 0;
    for (int j = 0; j < 48; j++) send_bit(j % 2 == 0);
    stop_bits();
    n_cmp++; if (beats.size() != 52) begin n_bad++; $display("FAIL bpsk_beats got %0d required 52", beats.size()); end
    n_cmp++; if (stall_cnt != 4) begin n_bad++; $display("FAIL bpsk_ready_low got %0d required 4", stall_cnt); end
    for (int s = 0; s < 52 && s < beats.size(); s++) begin
      if (is_pilot(s)) exp_i = (s == 46) ? -64 : 64;
      else begin exp_i = (k % 2 == 0) ? 64 : -64; k++; end
      n_cmp++; if (beats[s].idx !== 6'(s)) begin n_bad++; $display("FAIL bpsk_idx at %0d got %0d", s, beats[s].idx); end
      n_cmp++; if (int'(beats[s].i) !== exp_i) begin n_bad++; $display("FAIL bpsk_i slot %0d got %0d required %0d", s, beats[s].i, exp_i); end
      n_cmp++; if (beats[s].q !== 8'sd0) begin n_bad++; $display("FAIL bpsk_q slot %0d got %0d required 0", s, beats[s].q); end
      n_cmp++; if (beats[s].ss !== (s == 0)) begin n_bad++; $display("FAIL bpsk_ss slot %0d got %b", s, beats[s].ss); end
      n_cmp++; if (beats[s].se !== (s == 51)) begin n_bad++; $display("FAIL bpsk_se slot %0d got %b", s, beats[s].se); end
    end
    n_cmp++; if (Sym_Count !== 8'd1) begin n_bad++; $display("FAIL bpsk_sym_count got %0d required 1", Sym_Count); end
  endtask

  task automatic test_qam16();
    Mode = 2'b10;
    pulse_start();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    n_cmp++; if (Out_Valid !== 1'b0) begin n_bad++; $display("FAIL qam_early0 Out_Valid=%b required 0", Out_Valid); end
    send_bit(1'b0);
    n_cmp++; if (Out_Valid !== 1'b1) begin n_bad++; $display("FAIL qam_valid0 Out_Valid=%b required 1", Out_Valid); end
    n_cmp++; if (Out_Index !== 6'd0) begin n_bad++; $display("FAIL qam_idx0 got %0d required 0", Out_Index); end
    n_cmp++; if (Out_I !== -8'sd61) begin n_bad++; $display("FAIL qam_i0 got %0d required -61", Out_I); end
    n_cmp++; if (Out_Q !== 8'sd61) begin n_bad++; $display("FAIL qam_q0 got %0d required 61", Out_Q); end
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    n_cmp++; if (Out_Valid !== 1'b0) begin n_bad++; $display("FAIL qam_early1 Out_Valid=%b required 0", Out_Valid); end
    send_bit(1'b1);
    n_cmp++; if (Out_Valid !== 1'b1) begin n_bad++; $display("FAIL qam_valid1 Out_Valid=%b required 1", Out_Valid); end
    n_cmp++; if (Out_Index !== 6'd1) begin n_bad++; $display("FAIL qam_idx1 got %0d required 1", Out_Index); end
    n_cmp++; if (Out_I !== 8'sd20) begin n_bad++; $display("FAIL qam_i1 got %0d required 20", Out_I); end
    n_cmp++; if (Out_Q !== -8'sd20) begin n_bad++; $display("FAIL qam_q1 got %0d required -20", Out_Q); end
    stop_bits();
  endtask

  task automatic test_back_to_back();
    logic pol [0:4];
    int exp5;
    pol = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    Mode = 2'b00;
    beats.delete();
    pulse_start();
    for (int j = 0; j < 240; j++) send_bit(1'b0);
    stop_bits();
    n_cmp++; if (beats.size() != 260) begin n_bad++; $display("FAIL b2b_beats got %0d required 260", beats.size()); end
    for (int s = 0; s < 5 && beats.size() >= 260; s++) begin
      exp5 = pol[s] ? -64 : 64;
      n_cmp++; if (int'(beats[s*52+5].i) !== exp5) begin n_bad++; $display("FAIL b2b_pilot5 sym %0d got %0d required %0d", s, beats[s*52+5].i, exp5); end
      n_cmp++; if (int'(beats[s*52+46].i) !== -exp5) begin n_bad++; $display("FAIL b2b_pilot46 sym %0d got %0d required %0d", s, beats[s*52+46].i, -exp5); end
      n_cmp++; if (beats[s*52].ss !== 1'b1 || beats[s*52].idx !== 6'd0) begin n_bad++; $display("FAIL b2b_sym_start sym %0d ss=%b idx=%0d", s, beats[s*52].ss, beats[s*52].idx); end
    end
    n_cmp++; if (Sym_Count !== 8'd5) begin n_bad++; $display("FAIL b2b_sym_count got %0d required 5", Sym_Count); end
  endtask

  task automatic test_mode_switch();
    int k;
    int exp_i, exp_q;
    Mode = 2'b00;
    beats.delete();
    pulse_start();
    for (int j = 0; j < 48; j++) begin
      if (j == 20) Mode = 2'b01;
      send_bit(j % 2 == 1);
    end
    for (int j = 0; j < 96; j++) send_bit((j % 4) < 2);
    stop_bits();
    n_cmp++; if (beats.size() != 104) begin n_bad++; $display("FAIL msw_beats got %0d required 104", beats.size()); end
    for (int sym = 0; sym < 2 && beats.size() >= 104; sym++) begin
      k = 0;
      for (int s = 0; s < 52; s++) begin
        if (is_pilot(s)) begin
          exp_i = (s == 46) ? -64 : 64; exp_q = 0;
        end else if (sym == 0) begin
          exp_i = (k % 2 == 1) ? 64 : -64; exp_q = 0; k++;
        end else begin
          exp_i = (k % 2 == 0) ? 45 : -45; exp_q = exp_i; k++;
        end
        n_cmp++; if (int'(beats[sym*52+s].i) !== exp_i || int'(beats[sym*52+s].q) !== exp_q) begin
          n_bad++; $display("FAIL msw_iq sym %0d slot %0d got %0d/%0d required %0d/%0d", sym, s, beats[sym*52+s].i, beats[sym*52+s].q, exp_i, exp_q);
        end
      end
    end
    if (beats.size() >= 104) begin
      n_cmp++; if (beats[103].se !== 1'b1) begin n_bad++; $display("FAIL msw_sym_end got %b required 1", beats[103].se); end
    end
    n_cmp++; if (Sym_Count !== 8'd2) begin n_bad++; $display("FAIL msw_sym_count got %0d required 2", Sym_Count); end
    Mode = 2'b00;
  endtask

  task automatic test_start_abort();
    int n_se = 0;
    Mode = 2'b00;
    beats.delete();
    pulse_start();
    for (int j = 0; j < 66; j++) send_bit(1'b1);
    In_Valid = 1'b0;
    @(negedge Clock);
    n_cmp++; if (Sym_Count !== 8'd1) begin n_bad++; $display("FAIL abort_pre_count got %0d required 1", Sym_Count); end
    In_Bit = 1'b1; In_Valid = 1'b1; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0; In_Valid = 1'b0;
    @(negedge Clock);
    n_cmp++; if (beats.size() != 72) begin n_bad++; $display("FAIL abort_pre_beats got %0d required 72", beats.size()); end
    for (int s = 52; s < beats.size(); s++) if (beats[s].se) n_se++;
    n_cmp++; if (n_se != 0) begin n_bad++; $display("FAIL abort_sym_end got %0d required 0", n_se); end
    n_cmp++; if (Sym_Count !== 8'd0) begin n_bad++; $display("FAIL abort_count got %0d required 0", Sym_Count); end
    beats.delete();
    for (int j = 0; j < 48; j++) send_bit(j != 0);
    stop_bits();
    n_cmp++; if (beats.size() != 52) begin n_bad++; $display("FAIL abort_beats got %0d required 52", beats.size()); end
    if (beats.size() == 52) begin
      n_cmp++; if (beats[0].idx !== 6'd0 || beats[0].ss !== 1'b1 || beats[0].cnt !== 8'd0) begin
        n_bad++; $display("FAIL abort_first idx=%0d ss=%b cnt=%0d required 0/1/0", beats[0].idx, beats[0].ss, beats[0].cnt);
      end
      n_cmp++; if (int'(beats[0].i) !== -64) begin n_bad++; $display("FAIL abort_first_i got %0d required -64", beats[0].i); end
      n_cmp++; if (int'(beats[5].i) !== 64) begin n_bad++; $display("FAIL abort_pilot5 got %0d required 64", beats[5].i); end
      n_cmp++; if (int'(beats[46].i) !== -64) begin n_bad++; $display("FAIL abort_pilot46 got %0d required -64", beats[46].i); end
      n_cmp++; if (beats[51].se !== 1'b1) begin n_bad++; $display("FAIL abort_sym_end_last got %b required 1", beats[51].se); end
    end
    n_cmp++; if (Sym_Count !== 8'd1) begin n_bad++; $display("FAIL abort_post_count got %0d required 1", Sym_Count); end
  endtask

  initial begin
    test_reset();
    test_bpsk();
    test_qam16();
    test_back_to_back();
    test_mode_switch();
    test_start_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
